// File: rtl/alu_writeback_stage_if.sv
// rtl/alu_writeback_stage_if.sv - ALU-result intake, register-file writeback and flag bundle
// Bypass port signals exist only when ALU_WB_BYPASS_EN is defined.
interface alu_writeback_stage_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 2
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_rd;
  logic              in_z;
  logic              in_c;
  logic [ADDR_W-1:0] in_dst;
  logic              in_wflags;
  logic              wb_valid;
  logic              wb_ready;
  logic [DATA_W-1:0] wb_data;
  logic [ADDR_W-1:0] wb_addr;
  logic              flag_z;
  logic              flag_c;
  logic [CNT_W-1:0]  pending;
`ifdef ALU_WB_BYPASS_EN
  logic [ADDR_W-1:0] byp_addr;
  logic              byp_hit;
  logic [DATA_W-1:0] byp_data;

  modport master (
    output in_valid, in_rd, in_z, in_c, in_dst, in_wflags, wb_ready, byp_addr,
    input  in_ready, wb_valid, wb_data, wb_addr, flag_z, flag_c, pending, byp_hit, byp_data
  );
  modport slave (
    input  in_valid, in_rd, in_z, in_c, in_dst, in_wflags, wb_ready, byp_addr,
    output in_ready, wb_valid, wb_data, wb_addr, flag_z, flag_c, pending, byp_hit, byp_data
  );
`else
  modport master (
    output in_valid, in_rd, in_z, in_c, in_dst, in_wflags, wb_ready,
    input  in_ready, wb_valid, wb_data, wb_addr, flag_z, flag_c, pending
  );
  modport slave (
    input  in_valid, in_rd, in_z, in_c, in_dst, in_wflags, wb_ready,
    output in_ready, wb_valid, wb_data, wb_addr, flag_z, flag_c, pending
  );
`endif
endinterface

// File: rtl/alu_writeback_stage.sv
// rtl/alu_writeback_stage.sv - in-order retire queue from ALU to register file, flags committed at retire
// Optional operand-forwarding search enabled by defining ALU_WB_BYPASS_EN.
module alu_writeback_stage #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 2
) (
  input logic                  clk,
  input logic                  rst,
  alu_writeback_stage_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [DATA_W-1:0] rd_mem_q  [DEPTH];
  logic [ADDR_W-1:0] dst_mem_q [DEPTH];
  logic [DEPTH-1:0]  z_mem_q;
  logic [DEPTH-1:0]  c_mem_q;
  logic [DEPTH-1:0]  wf_mem_q;

  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              flag_z_q, flag_z_d;
  logic              flag_c_q, flag_c_d;

  logic push;
  logic pop;
  logic in_ready;
  logic wb_valid;

  // Readiness depends on registered occupancy only, so a full queue never passes through.
  assign in_ready = (count_q < CNT_W'(DEPTH));
  assign wb_valid = (count_q != '0);
  assign push     = bus.in_valid & in_ready;
  assign pop      = wb_valid & bus.wb_ready;

  assign bus.in_ready = in_ready;
  assign bus.wb_valid = wb_valid;
  assign bus.wb_data  = wb_valid ? rd_mem_q[rd_ptr_q]  : '0;
  assign bus.wb_addr  = wb_valid ? dst_mem_q[rd_ptr_q] : '0;
  assign bus.flag_z   = flag_z_q;
  assign bus.flag_c   = flag_c_q;
  assign bus.pending  = count_q;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    flag_z_d = flag_z_q;
    flag_c_d = flag_c_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (wf_mem_q[rd_ptr_q]) begin
        flag_z_d = z_mem_q[rd_ptr_q];
        flag_c_d = c_mem_q[rd_ptr_q];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      flag_z_q <= 1'b0;
      flag_c_q <= 1'b0;
      z_mem_q  <= '0;
      c_mem_q  <= '0;
      wf_mem_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rd_mem_q[i]  <= '0;
        dst_mem_q[i] <= '0;
      end
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      flag_z_q <= flag_z_d;
      flag_c_q <= flag_c_d;
      if (push) begin
        rd_mem_q[wr_ptr_q]  <= bus.in_rd;
        dst_mem_q[wr_ptr_q] <= bus.in_dst;
        z_mem_q[wr_ptr_q]   <= bus.in_z;
        c_mem_q[wr_ptr_q]   <= bus.in_c;
        wf_mem_q[wr_ptr_q]  <= bus.in_wflags;
      end
    end
  end

`ifdef ALU_WB_BYPASS_EN
  logic              byp_hit;
  logic [DATA_W-1:0] byp_data;
  logic [PTR_W-1:0]  byp_idx;

  // Walk oldest to youngest so the last match wins; the head counts even while popping.
  always_comb begin
    byp_hit  = 1'b0;
    byp_data = '0;
    byp_idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      byp_idx = rd_ptr_q + PTR_W'(i);
      if ((CNT_W'(i) < count_q) && (dst_mem_q[byp_idx] == bus.byp_addr)) begin
        byp_hit  = 1'b1;
        byp_data = rd_mem_q[byp_idx];
      end
    end
  end

  assign bus.byp_hit  = byp_hit;
  assign bus.byp_data = byp_data;
`endif
endmodule
